// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the memory-side datapath.
// Holds the arbiter FSM encoding and the cacheline width.
package rv32i_types;

  localparam int unsigned CL_LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_BUSY = 2'b01,
    D_BUSY = 2'b10,
    DONE   = 2'b11
  } arb_state_t;

endpackage

// File: rtl/cacheline_arbiter_control.sv
// Arbiter FSM: grant decision, starvation counter and
// ownership tracking for the shared cacheline port.
module cacheline_arbiter_control
  import rv32i_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic mem_resp_i,
  output logic grant_d_o,
  output logic latch_en_o,
  output logic busy_o,
  output logic own_i_o,
  output logic own_d_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       d_wins;

  // Data cache keeps priority until it has starved fetch LIMIT times.
  assign d_wins = d_req_i && (!i_req_i || starve_q < LIMIT);

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    grant_d_o  = 1'b0;
    latch_en_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d    = D_BUSY;
          grant_d_o  = 1'b1;
          latch_en_o = 1'b1;
          if (i_req_i) starve_d = starve_q + 4'd1;
        end else if (i_req_i) begin
          state_d    = I_BUSY;
          latch_en_o = 1'b1;
          starve_d   = '0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp_i) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign own_i_o = (state_q == I_BUSY);
  assign own_d_o = (state_q == D_BUSY);
  assign busy_o  = own_i_o | own_d_o;

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one physical-memory cacheline port between I$ and D$.
// Latches the winner's command and routes the response back.
module cacheline_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned LINE_WIDTH   = CL_LINE_WIDTH,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int unsigned OFF = $clog2(LINE_WIDTH / 8);

  logic grant_d, latch_en, busy, own_i, own_d;

  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_sel;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  cacheline_arbiter_control #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_req_i   (icache_pmem_read),
    .d_req_i   (dcache_pmem_read | dcache_pmem_write),
    .mem_resp_i(pmem_resp),
    .grant_d_o (grant_d),
    .latch_en_o(latch_en),
    .busy_o    (busy),
    .own_i_o   (own_i),
    .own_d_o   (own_d)
  );

  assign addr_sel = grant_d ? dcache_pmem_address
                            : icache_pmem_address;

  always_comb begin
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (latch_en) begin
      // Read+write together resolves to a writeback.
      wr_d    = grant_d & dcache_pmem_write;
      addr_d  = {addr_sel[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
      wdata_d = dcache_pmem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign pmem_read    = busy & ~wr_q;
  assign pmem_write   = busy & wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign icache_pmem_resp  = own_i & pmem_resp;
  assign dcache_pmem_resp  = own_d & pmem_resp;
  assign icache_pmem_rdata = own_i ? pmem_rdata : '0;
  assign dcache_pmem_rdata = own_d ? pmem_rdata : '0;

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Arbitrates the single physical-memory cacheline port between the instruction cache and the data cache behind the pipelined datapath. Each cache issues whole-line reads (the data cache also issues writebacks). The arbiter grants one requester at a time, latches its command, and drives it onto physical memory. It returns the response only to the owner and applies bounded data-cache priority so instruction fetch cannot starve.

## Interface
- LINE_WIDTH, 256, cacheline width in bits; must be a power of two ≥ 64
- ADDR_WIDTH, 32, byte address width
- STARVE_LIMIT, 4, consecutive data-cache grants allowed while an instruction request waits; range 1..15
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- icache_pmem_read  in  1  instruction cache line read request, level, held until resp
- icache_pmem_address  in  ADDR_WIDTH  instruction line address
- icache_pmem_rdata  out  LINE_WIDTH  returned line
- icache_pmem_resp  out  1  one-cycle completion pulse
- dcache_pmem_read  in  1  data cache line read request, held until resp
- dcache_pmem_write  in  1  data cache writeback request, held until resp
- dcache_pmem_address  in  ADDR_WIDTH  data line address
- dcache_pmem_wdata  in  LINE_WIDTH  writeback line
- dcache_pmem_rdata  out  LINE_WIDTH  returned line
- dcache_pmem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  physical memory read command
- pmem_write  out  1  physical memory write command
- pmem_address  out  ADDR_WIDTH  line-aligned address
- pmem_wdata  out  LINE_WIDTH  write line
- pmem_rdata  in  LINE_WIDTH  read line, valid with pmem_resp
- pmem_resp  in  1  completion pulse from memory

## Operation
- States:
  - IDLE: no command.
  - I_BUSY: instruction transfer in flight.
  - D_BUSY: data transfer in flight.
  - DONE: one-cycle recovery.
- IDLE grant decision, sampled at the clock edge:
  - The data cache wins if it requests and either no instruction request is pending or starve_cnt < STARVE_LIMIT.
  - Otherwise the instruction cache wins if it requests.
  - Otherwise the arbiter stays in IDLE.
- On grant the arbiter latches the following, which are held constant through BUSY:
  - op: write if dcache_pmem_write, else read. Read and write asserted together is treated as a write.
  - address, with the low log2(LINE_WIDTH/8) bits forced to 0.
  - wdata.
- Requester input changes during BUSY or DONE are ignored.
- In BUSY, pmem_read or pmem_write is driven from the latched op, together with the latched address and wdata.
- On pmem_resp in BUSY:
  - The owner's *_pmem_resp is high in the same cycle.
  - The owner's *_pmem_rdata equals pmem_rdata.
  - The state goes to DONE.
- In DONE all commands and responses are low. The next state is IDLE unconditionally, which gives the requester one cycle to drop its request.
- starve_cnt is a 4-bit register:
  - +1 (saturating at STARVE_LIMIT) on a data-cache grant while icache_pmem_read is high.
  - Cleared on an instruction-cache grant.
  - Unchanged otherwise.
- A non-owner's *_pmem_resp is always 0.
- *_pmem_rdata outputs: pmem_rdata is routed to the owner while busy; both outputs are 0 otherwise.
- pmem_resp outside BUSY is ignored.

## Timing
- Reset values:
  - State is IDLE and starve_cnt is 0.
  - Latched op, address and wdata are 0.
  - All outputs are 0.
- Reset asserted mid-transfer abandons the transfer. Commands are low from the cycle after the reset edge, and no resp is issued for the abandoned transfer.
- Request high in IDLE during cycle 0 → pmem command high from cycle 1.
- pmem_resp in cycle n → requester resp in cycle n, DONE in cycle n+1, IDLE in cycle n+2.
- Earliest next command is at cycle n+3.
- Minimum transfer occupancy is 3 cycles (grant, a same-cycle response, DONE).
- Simultaneous requests in IDLE follow the grant rule. The loser's request is held and is served at the next IDLE.
- All commands and the latched fields are registered. Resp and rdata are combinational from pmem_resp and pmem_rdata.

## Structure
- Add arb_state_t (IDLE, I_BUSY, D_BUSY, DONE) to the shared rv32i_types package.
- Add a shared line-width constant to the same package.
- Split into two pieces:
  - Sub-module cacheline_arbiter_control holds the FSM, starve_cnt and grant decode, and outputs the owner, the busy indication and a latch enable.
  - The top holds the command/address/wdata registers and the response routing.

## Test plan
- Lone icache read, address 0x0000_1234, memory resp at cycle 3 with line 0xA5…A5:
  - pmem_read is high in cycles 1–3 with pmem_address = 0x0000_1220.
  - icache_pmem_resp is high in cycle 3 with rdata 0xA5…A5.
  - dcache_pmem_resp stays 0 throughout.
- Simultaneous icache read and dcache write at reset (starve_cnt 0):
  - The dcache is granted first; pmem_write is high with the latched wdata.
  - The icache is granted at the following IDLE.
- Both caches request continuously with STARVE_LIMIT=4:
  - The grant sequence is D,D,D,D,I,D,D,D,D,I.
- dcache asserts read and write together:
  - Only pmem_write is issued.
  - dcache address and wdata changes mid-transfer do not alter pmem_address or pmem_wdata.
- rst pulsed during D_BUSY before pmem_resp:
  - pmem_write is 0 the cycle after the edge and no resp is issued.
  - A subsequent icache request is served normally.
- pmem_resp pulse injected in IDLE:
  - No resp outputs are asserted and the state remains IDLE.
